// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, bounce filter and
// press / release / long-press event pulses with a held level.
module button_debouncer #(
    parameter int CLK_FREQ      = 12000000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000,
    parameter bit ACTIVE_LEVEL  = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic held
);

    localparam int DEB_CYCLES  = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYCLES = CLK_FREQ / 1000 * LONG_PRESS_MS;
    localparam int DEB_W       = (DEB_CYCLES >= 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int LONG_W      = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

    generate
        if (DEB_CYCLES < 1 || LONG_CYCLES <= DEB_CYCLES) begin : g_bad_params
            $error("button_debouncer: need DEB_CYCLES >= 1 and LONG_CYCLES > DEB_CYCLES");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RELEASED      = 2'd0,
        ST_ARMING_PRESS  = 2'd1,
        ST_PRESSED       = 2'd2,
        ST_ARMING_RELEASE = 2'd3
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    state_t            r_state;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [LONG_W-1:0] r_hold_cnt;
    logic              r_level;
    logic              r_press_pulse;
    logic              r_release_pulse;
    logic              r_long_pulse;
    logic              r_held;

    logic              w_s;
    logic              w_deb_done;
    logic              w_release_now;
    logic              w_hold_sat;
    logic              w_hold_fire;

    assign w_s           = (r_sync2 == ACTIVE_LEVEL);
    assign w_deb_done    = (r_deb_cnt == DEB_LAST);
    assign w_release_now = !w_s && w_deb_done;
    assign w_hold_sat    = (r_hold_cnt == LONG_MAX);
    assign w_hold_fire   = (r_hold_cnt == LONG_LAST);

    assign level            = r_level;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_pulse;
    assign held             = r_held;

    // Synchroniser idles at "not pressed" so reset exit never looks like an edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= ~ACTIVE_LEVEL;
            r_sync2 <= ~ACTIVE_LEVEL;
        end else begin
            r_sync1 <= button_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM with hold timer and registered event outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_RELEASED;
            r_deb_cnt       <= '0;
            r_hold_cnt      <= '0;
            r_level         <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_held          <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            case (r_state)
                ST_RELEASED, ST_ARMING_PRESS: begin
                    if (w_s) begin
                        if (w_deb_done) begin
                            r_state       <= ST_PRESSED;
                            r_deb_cnt     <= '0;
                            r_hold_cnt    <= '0;
                            r_level       <= 1'b1;
                            r_press_pulse <= 1'b1;
                        end else begin
                            r_state   <= ST_ARMING_PRESS;
                            r_deb_cnt <= r_deb_cnt + DEB_ONE;
                        end
                    end else begin
                        r_state   <= ST_RELEASED;
                        r_deb_cnt <= '0;
                    end
                end
                ST_PRESSED, ST_ARMING_RELEASE: begin
                    if (w_s) begin
                        r_state   <= ST_PRESSED;
                        r_deb_cnt <= '0;
                    end else if (w_deb_done) begin
                        r_state         <= ST_RELEASED;
                        r_deb_cnt       <= '0;
                        r_hold_cnt      <= '0;
                        r_level         <= 1'b0;
                        r_release_pulse <= 1'b1;
                        r_held          <= 1'b0;
                    end else begin
                        r_state   <= ST_ARMING_RELEASE;
                        r_deb_cnt <= r_deb_cnt + DEB_ONE;
                    end
                    // A release edge wins over a long press landing on the same cycle
                    if (!w_release_now && !w_hold_sat) begin
                        r_hold_cnt <= r_hold_cnt + LONG_ONE;
                        if (w_hold_fire) begin
                            r_long_pulse <= 1'b1;
                            r_held       <= 1'b1;
                        end else begin
                            r_long_pulse <= 1'b0;
                        end
                    end else begin
                        r_long_pulse <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_RELEASED;
                    r_deb_cnt <= '0;
                    r_level   <= 1'b0;
                    r_held    <= 1'b0;
                end
            endcase
        end
    end

endmodule
